if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction fetch stage of ARVI's datapath; supplies the instruction word and PC consumed by the decode stage.
- Owns the PC register and drives a single-outstanding req/ack handshake to instruction memory.
- Absorbs decode back-pressure with a 1-entry skid buffer, and handles branch/jump redirects, including one that arrives while a fetch is in flight.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; width `XLEN.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_stall  in  1  decode/hazard stall; output slot must hold.
- i_redirect  in  1  taken branch/jump/exception redirect.
- i_redirect_pc  in  `XLEN  redirect target; bits [1:0] ignored (forced 0).
- o_imem_req  out  1  fetch request.
- o_imem_addr  out  `XLEN  fetch address, word aligned.
- i_imem_ack  in  1  one-cycle pulse: i_imem_data valid for o_imem_addr.
- i_imem_data  in  32  fetched instruction word.
- o_inst  out  32  instruction to decode.
- o_pc  out  `XLEN  PC of o_inst.
- o_valid  out  1  o_inst/o_pc hold a real instruction.

Behaviour:
- Reset (asynchronous assert, any state, mid-fetch included) sets:
  - o_valid=0, o_inst=32'h0000_0013 (NOP), o_pc=RESET_PC.
  - o_imem_req=0, o_imem_addr=RESET_PC, skid buffer empty, state FETCH.
  - Any ack pending at reset is forgotten.
- First rising edge after reset release: o_imem_req=1, o_imem_addr=RESET_PC.
- Memory protocol:
  - o_imem_addr is stable while o_imem_req=1 until the ack cycle.
  - At most one request is outstanding.
  - An ack in the same cycle as the request is legal (0-wait memory).
- Output slot "free" = !o_valid || !i_stall.
- States:
  - FETCH: req high.
    - On ack with slot free: the next edge loads o_inst=data, o_pc=addr, o_valid=1; the address advances by 4 and req stays high. Sustains 1 instr/cycle on 0-wait memory.
    - On ack with slot not free: data and address go into the skid buffer; address advances by 4; go to FULL.
    - No ack: hold.
  - FULL: req low.
    - When the slot becomes free, the skid contents move to the output; req goes high the same edge; return to FETCH.
  - DISCARD: req high with the old address, unchanged.
    - On ack: drop data; next edge o_imem_addr=target, req high, go to FETCH.
- If no fetched instruction is ready while the slot is free, o_valid=0 next edge and o_inst/o_pc hold their last value.
- While i_stall=1 and o_valid=1: o_inst, o_pc and o_valid are unchanged.
- Redirect has priority over stall, ack and skid. On the next edge:
  - o_valid=0, skid emptied, PC target captured.
  - If in FETCH with no ack this cycle: go to DISCARD.
  - If ack this cycle, or state was FULL: o_imem_addr=target, req high, FETCH; the acked data is dropped.
  - If in DISCARD: the target is replaced by the newest one; stay in DISCARD.
- Address arithmetic: +4 modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0, no flag.
- Latency: request to o_valid is ack cycle + 1 edge.

Test Plan:
- Reset release, 0-wait memory returning addr>>2 as data:
  - o_imem_addr 0,4,8 on consecutive cycles.
  - o_valid rises one edge after the first ack; o_pc 0,4,8 back-to-back with o_inst 0,1,2.
- Steady fetch, then i_stall held 3 cycles:
  - o_inst/o_pc frozen.
  - One further ack lands in skid; req drops.
  - On release: skid instruction appears next edge; then fetch resumes at +8 beyond the frozen PC, with no duplicate or skipped PC.
- 3-wait-state memory, i_redirect=1 with target 32'h100 one cycle after req:
  - req stays on the old addr until ack; that data is never shown.
  - Next request is 32'h100; next o_valid has o_pc=32'h100.
- Redirect to 32'h203 coincident with ack and i_stall=1:
  - o_valid=0 next edge, ack data dropped, o_imem_addr=32'h200.
- Reset asserted mid-wait (req high, no ack):
  - All outputs at reset values immediately.
  - A stale ack during reset is ignored; after release, fetch restarts at RESET_PC.
- RESET_PC=32'hFFFF_FFFC:
  - Second fetch address is 32'h0000_0000; o_pc sequence FFFF_FFFC then 0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding req/ack fetch,
// buffers one instruction under decode back-pressure and handles redirects.
`ifndef XLEN
`define XLEN 32
`endif

module if_stage #(
    parameter logic [`XLEN-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [`XLEN-1:0]  i_redirect_pc,
    output logic              o_imem_req,
    output logic [`XLEN-1:0]  o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [31:0]       i_imem_data,
    output logic [31:0]       o_inst,
    output logic [`XLEN-1:0]  o_pc,
    output logic              o_valid
);
    localparam int          XL  = `XLEN;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {FETCH = 2'd0, FULL = 2'd1, DISCARD = 2'd2} state_t;

    state_t          state_reg, state_next;
    logic            req_reg, req_next;
    logic            valid_reg, valid_next;
    logic [XL-1:0]   addr_reg, addr_next;
    logic [XL-1:0]   target_reg, target_next;
    logic [XL-1:0]   pc_reg, pc_next;
    logic [XL-1:0]   skid_pc_reg, skid_pc_next;
    logic [31:0]     inst_reg, inst_next;
    logic [31:0]     skid_inst_reg, skid_inst_next;

    logic            ack;
    logic            slot_free;
    logic [XL-1:0]   redirect_aligned;
    logic [XL-1:0]   addr_inc;

    // An ack only counts against a live request; stray acks after reset are ignored.
    assign ack              = i_imem_ack && req_reg;
    assign slot_free        = !valid_reg || !i_stall;
    assign redirect_aligned = {i_redirect_pc[XL-1:2], 2'b00};
    assign addr_inc         = addr_reg + XL'(4);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (i_redirect) begin
            case (state_reg)
                FETCH:   state_next = (ack || !req_reg) ? FETCH : DISCARD;
                FULL:    state_next = FETCH;
                default: state_next = ack ? FETCH : DISCARD;
            endcase
        end else begin
            case (state_reg)
                FETCH:   if (ack && !slot_free) state_next = FULL;
                FULL:    if (slot_free) state_next = FETCH;
                default: if (ack) state_next = FETCH;
            endcase
        end
    end

    always_comb begin
        req_next       = 1'b1;
        addr_next      = addr_reg;
        target_next    = target_reg;
        valid_next     = valid_reg;
        inst_next      = inst_reg;
        pc_next        = pc_reg;
        skid_inst_next = skid_inst_reg;
        skid_pc_next   = skid_pc_reg;
        if (i_redirect) begin
            valid_next  = 1'b0;
            target_next = redirect_aligned;
            // With nothing in flight the target can be requested immediately.
            if (state_next == FETCH) addr_next = redirect_aligned;
        end else begin
            if (slot_free) valid_next = 1'b0;
            case (state_reg)
                FETCH: begin
                    if (ack) begin
                        addr_next = addr_inc;
                        if (slot_free) begin
                            valid_next = 1'b1;
                            inst_next  = i_imem_data;
                            pc_next    = addr_reg;
                        end else begin
                            skid_inst_next = i_imem_data;
                            skid_pc_next   = addr_reg;
                            req_next       = 1'b0;
                        end
                    end
                end
                FULL: begin
                    if (slot_free) begin
                        valid_next = 1'b1;
                        inst_next  = skid_inst_reg;
                        pc_next    = skid_pc_reg;
                    end else begin
                        req_next = 1'b0;
                    end
                end
                default: begin
                    if (ack) addr_next = target_reg;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            req_reg       <= 1'b0;
            valid_reg     <= 1'b0;
            addr_reg      <= RESET_PC;
            target_reg    <= RESET_PC;
            pc_reg        <= RESET_PC;
            inst_reg      <= NOP;
            skid_pc_reg   <= '0;
            skid_inst_reg <= '0;
        end else begin
            req_reg       <= req_next;
            valid_reg     <= valid_next;
            addr_reg      <= addr_next;
            target_reg    <= target_next;
            pc_reg        <= pc_next;
            inst_reg      <= inst_next;
            skid_pc_reg   <= skid_pc_next;
            skid_inst_reg <= skid_inst_next;
        end
    end

    assign o_imem_req  = req_reg;
    assign o_imem_addr = addr_reg;
    assign o_inst      = inst_reg;
    assign o_pc        = pc_reg;
    assign o_valid     = valid_reg;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand sequences for redirect/reset/wrap,
// then randomized traffic checked against an instruction-stream scoreboard.
`timescale 1ns/1ps

module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, redirect = 1'b0, ack = 1'b0;
    logic [31:0] redirect_pc = '0, imem_data = '0;
    logic        req, valid;
    logic [31:0] addr, inst, pc;

    logic        stall2 = 1'b0, redirect2 = 1'b0, ack2 = 1'b0;
    logic [31:0] redirect_pc2 = '0, data2 = '0;
    logic        req2, valid2;
    logic [31:0] addr2, inst2, pc2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .i_clk(clk), .i_rstn(rst_n), .i_stall(stall), .i_redirect(redirect),
        .i_redirect_pc(redirect_pc), .o_imem_req(req), .o_imem_addr(addr),
        .i_imem_ack(ack), .i_imem_data(imem_data), .o_inst(inst), .o_pc(pc),
        .o_valid(valid)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .i_clk(clk), .i_rstn(rst_n), .i_stall(stall2), .i_redirect(redirect2),
        .i_redirect_pc(redirect_pc2), .o_imem_req(req2), .o_imem_addr(addr2),
        .i_imem_ack(ack2), .i_imem_data(data2), .o_inst(inst2), .o_pc(pc2),
        .o_valid(valid2)
    );

    typedef struct {
        logic        stall;
        logic        ack;
        logic [31:0] data;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 1'b0; redirect = 1'b0; ack = 1'b0; redirect_pc = '0; imem_data = '0;
        ack2 = 1'b0; data2 = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        chk("reset req", {31'd0, req}, 32'd0);
        chk("reset addr", addr, 32'd0);
        chk("reset valid", {31'd0, valid}, 32'd0);
        chk("reset inst", inst, NOP);
        chk("reset pc", pc, 32'd0);
        rst_n = 1'b1;
    endtask

    logic        p_valid, p_stall, p_redir;
    logic [31:0] p_pc, p_inst, p_rpc;
    logic [31:0] exp_pc, pend_addr;
    logic        pending, ack_now;
    int          wait_cnt, delivered;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000, NOP};
        tbl[1]  = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b1, 32'h000, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 32'h1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h004, 32'h1};
        tbl[3]  = '{1'b0, 1'b1, 32'h2, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h008, 32'h2};
        tbl[4]  = '{1'b1, 1'b1, 32'h3, 1'b0, 32'h0,   1'b0, 32'h010, 1'b1, 32'h008, 32'h2};
        tbl[5]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h010, 1'b1, 32'h008, 32'h2};
        tbl[6]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h010, 1'b1, 32'h008, 32'h2};
        tbl[7]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h00C, 32'h3};
        tbl[8]  = '{1'b0, 1'b1, 32'h4, 1'b0, 32'h0,   1'b1, 32'h014, 1'b1, 32'h010, 32'h4};
        tbl[9]  = '{1'b0, 1'b1, 32'h5, 1'b0, 32'h0,   1'b1, 32'h018, 1'b1, 32'h014, 32'h5};
        tbl[10] = '{1'b1, 1'b1, 32'h6, 1'b1, 32'h203, 1'b1, 32'h200, 1'b0, 32'h014, 32'h5};
        tbl[11] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h014, 32'h5};
        tbl[12] = '{1'b0, 1'b1, 32'h80, 1'b0, 32'h0,  1'b1, 32'h204, 1'b1, 32'h200, 32'h80};

        // Reset release, 0-wait fetch, stall into skid, redirect with ack and stall.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            stall = tbl[i].stall; ack = tbl[i].ack; imem_data = tbl[i].data;
            redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
            step();
            $display("vec %0d: req=%0b addr=%h valid=%0b pc=%h inst=%h", i, req, addr, valid, pc, inst);
            chk($sformatf("vec%0d req", i), {31'd0, req}, {31'd0, tbl[i].e_req});
            chk($sformatf("vec%0d addr", i), addr, tbl[i].e_addr);
            chk($sformatf("vec%0d valid", i), {31'd0, valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("vec%0d pc", i), pc, tbl[i].e_pc);
            chk($sformatf("vec%0d inst", i), inst, tbl[i].e_inst);
        end

        // 3-wait memory with a redirect one cycle into the request.
        do_reset();
        clear_inputs();
        step();
        chk("wait req on", {31'd0, req}, 32'd1);
        step();
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        $display("seq redirect-wait: req=%0b addr=%h valid=%0b", req, addr, valid);
        chk("wait old addr held", addr, 32'h0);
        chk("wait valid after redirect", {31'd0, valid}, 32'd0);
        step();
        chk("wait old addr held2", addr, 32'h0);
        chk("wait req held", {31'd0, req}, 32'd1);
        ack = 1'b1; imem_data = 32'hBAD0_0000;
        step();
        chk("wait target addr", addr, 32'h100);
        chk("wait stale data hidden", {31'd0, valid}, 32'd0);
        imem_data = memfn(32'h100);
        step();
        ack = 1'b0;
        $display("seq redirect-wait: valid=%0b pc=%h inst=%h", valid, pc, inst);
        chk("wait target valid", {31'd0, valid}, 32'd1);
        chk("wait target pc", pc, 32'h100);
        chk("wait target inst", inst, 32'h40);

        // Asynchronous reset mid-request, stale ack around reset.
        step();
        #3 rst_n = 1'b0;
        #1;
        $display("seq async-reset: req=%0b addr=%h valid=%0b", req, addr, valid);
        chk("async req", {31'd0, req}, 32'd0);
        chk("async addr", addr, 32'd0);
        chk("async valid", {31'd0, valid}, 32'd0);
        chk("async inst", inst, NOP);
        chk("async pc", pc, 32'd0);
        ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        step();
        step();
        chk("async held valid", {31'd0, valid}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("restart req", {31'd0, req}, 32'd1);
        chk("restart addr", addr, 32'd0);
        chk("restart stale ack ignored", {31'd0, valid}, 32'd0);
        imem_data = memfn(32'h0);
        step();
        ack = 1'b0;
        chk("restart pc", pc, 32'd0);
        chk("restart inst", inst, 32'd0);
        chk("restart valid", {31'd0, valid}, 32'd1);

        // Address wrap from RESET_PC = FFFF_FFFC.
        do_reset();
        chk("wrap reset addr", addr2, 32'hFFFF_FFFC);
        step();
        chk("wrap first req", {31'd0, req2}, 32'd1);
        chk("wrap first addr", addr2, 32'hFFFF_FFFC);
        ack2 = 1'b1; data2 = memfn(32'hFFFF_FFFC);
        step();
        chk("wrap second addr", addr2, 32'h0);
        chk("wrap pc0", pc2, 32'hFFFF_FFFC);
        chk("wrap inst0", inst2, 32'h3FFF_FFFF);
        data2 = memfn(32'h0);
        step();
        ack2 = 1'b0;
        $display("seq wrap: pc=%h inst=%h addr=%h", pc2, inst2, addr2);
        chk("wrap pc1", pc2, 32'h0);
        chk("wrap valid1", {31'd0, valid2}, 32'd1);

        // Randomized traffic against an instruction-stream scoreboard.
        do_reset();
        exp_pc = 32'h0; pending = 1'b0; pend_addr = '0; wait_cnt = 0; delivered = 0;
        p_valid = 1'b0; p_stall = 1'b0; p_redir = 1'b0; p_pc = '0; p_inst = '0; p_rpc = '0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                if (p_redir) begin
                    chk("rnd redirect clears valid", {31'd0, valid}, 32'd0);
                    exp_pc = {p_rpc[31:2], 2'b00};
                end else if (p_valid && p_stall) begin
                    chk("rnd stall valid", {31'd0, valid}, 32'd1);
                    chk("rnd stall pc", pc, p_pc);
                    chk("rnd stall inst", inst, p_inst);
                end else if (valid) begin
                    chk("rnd stream pc", pc, exp_pc);
                    chk("rnd stream inst", inst, memfn(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    delivered++;
                end else begin
                    chk("rnd idle pc", pc, p_pc);
                    chk("rnd idle inst", inst, p_inst);
                end
            end
            ack_now = 1'b0;
            if (pending) chk("rnd req held", {31'd0, req}, 32'd1);
            if (req) begin
                if (pending) begin
                    chk("rnd addr stable", addr, pend_addr);
                end else begin
                    pending = 1'b1;
                    pend_addr = addr;
                    wait_cnt = int'($urandom_range(0, 3));
                end
                if (wait_cnt == 0) begin
                    ack_now = 1'b1;
                    pending = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end else begin
                pending = 1'b0;
            end
            ack = ack_now;
            imem_data = ack_now ? memfn(pend_addr) : $urandom;
            stall = ($urandom_range(0, 99) < 30);
            redirect = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            else redirect_pc = $urandom;
            p_valid = valid; p_stall = stall; p_redir = redirect;
            p_pc = pc; p_inst = inst; p_rpc = redirect_pc;
            step();
        end
        checks++;
        if (delivered < 200) begin
            failures++;
            $display("FAIL rnd delivered actual=%0d required>=200", delivered);
        end
        $display("random phase: delivered=%0d instructions", delivered);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
